// File: rtl/bit_unstuffer.sv
// Receive-path bit unstuffer: drops the stuffed 0 after MAX_ONES consecutive 1s,
// flags stuffing violations, counts delivered bits and marks packet end.
module bit_unstuffer #(
    parameter int MAX_ONES  = 6,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_bit,
    input  logic                 nrzi_sending,
    output logic                 out_bit,
    output logic                 bs_sending,
    output logic                 bs_error,
    output logic                 bs_done,
    output logic [CNT_WIDTH-1:0] bit_count,
    output logic [1:0]           fsm_state
);

    // Stream handshake: out_bit is meaningful only in cycles where bs_sending=1;
    // there is no backpressure, the consumer must take every valid bit.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        ERROR = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [2:0]           ones_cnt, ones_nxt;
    logic [2:0]           eff_ones;
    logic [CNT_WIDTH-1:0] eff_count, count_nxt;
    logic                 out_nxt, sending_nxt, error_nxt, done_nxt;

    assign fsm_state = state;

    always_comb begin
        state_nxt   = state;
        ones_nxt    = ones_cnt;
        count_nxt   = bit_count;
        out_nxt     = out_bit;
        sending_nxt = 1'b0;
        error_nxt   = 1'b0;
        done_nxt    = 1'b0;
        eff_ones    = ones_cnt;
        eff_count   = bit_count;

        // A packet start behaves like RECV with a fresh run length and count.
        if (state == IDLE) begin
            eff_ones  = 3'd0;
            eff_count = '0;
        end

        case (state)
            IDLE, RECV: begin
                if (nrzi_sending) begin
                    state_nxt = RECV;
                    count_nxt = eff_count;
                    if (eff_ones < 3'(MAX_ONES)) begin
                        out_nxt     = in_bit;
                        sending_nxt = 1'b1;
                        ones_nxt    = in_bit ? eff_ones + 3'd1 : 3'd0;
                        if (eff_count != {CNT_WIDTH{1'b1}}) begin
                            count_nxt = eff_count + CNT_WIDTH'(1);
                        end
                    end else if (!in_bit) begin
                        ones_nxt = 3'd0;
                    end else begin
                        error_nxt = 1'b1;
                        state_nxt = ERROR;
                    end
                end else if (state == RECV) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                    ones_nxt  = 3'd0;
                end
            end
            ERROR: begin
                if (!nrzi_sending) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                    ones_nxt  = 3'd0;
                end
            end
            default: begin
                state_nxt = IDLE;
                ones_nxt  = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            ones_cnt   <= 3'd0;
            out_bit    <= 1'b0;
            bs_sending <= 1'b0;
            bs_error   <= 1'b0;
            bs_done    <= 1'b0;
            bit_count  <= '0;
        end else begin
            state      <= state_nxt;
            ones_cnt   <= ones_nxt;
            out_bit    <= out_nxt;
            bs_sending <= sending_nxt;
            bs_error   <= error_nxt;
            bs_done    <= done_nxt;
            bit_count  <= count_nxt;
        end
    end

endmodule

// File: tb/tb_bit_unstuffer.sv
// Directed bench for bit_unstuffer: a 16-bit-count instance and a 3-bit-count
// instance share one stimulus stream.
module tb_bit_unstuffer;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_bit;
    logic        nrzi_sending;
    logic        out_bit, bs_sending, bs_error, bs_done;
    logic [15:0] bit_count;
    logic [1:0]  fsm_state;
    logic        sat_out_bit, sat_sending, sat_error, sat_done;
    logic [2:0]  sat_count;
    logic [1:0]  sat_state;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    bit_unstuffer #(.MAX_ONES(6), .CNT_WIDTH(16)) dut (
        .clock(clock), .reset(reset), .in_bit(in_bit), .nrzi_sending(nrzi_sending),
        .out_bit(out_bit), .bs_sending(bs_sending), .bs_error(bs_error),
        .bs_done(bs_done), .bit_count(bit_count), .fsm_state(fsm_state)
    );

    bit_unstuffer #(.MAX_ONES(6), .CNT_WIDTH(3)) dut_sat (
        .clock(clock), .reset(reset), .in_bit(in_bit), .nrzi_sending(nrzi_sending),
        .out_bit(sat_out_bit), .bs_sending(sat_sending), .bs_error(sat_error),
        .bs_done(sat_done), .bit_count(sat_count), .fsm_state(sat_state)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Apply one input cycle, then sample registered outputs 1 time unit after the edge.
    task automatic drive(input logic b, input logic s);
        in_bit       = b;
        nrzi_sending = s;
        @(posedge clock);
        #1;
    endtask

    task automatic expect_outs(input string tag, input logic s, input logic o,
                               input logic e, input logic d);
        check({tag, "_sending"}, bs_sending, s);
        check({tag, "_out"},     out_bit,    o);
        check({tag, "_error"},   bs_error,   e);
        check({tag, "_done"},    bs_done,    d);
    endtask

    logic [23:0] vec24;
    logic [0:7]  seq_stuff;
    logic [0:7]  exp_send_stuff;
    logic [0:12] seq_run;
    logic        exp_out;

    initial begin
        // Reset with an active-looking input to show reset dominates
        reset        = 1'b1;
        in_bit       = 1'b1;
        nrzi_sending = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        expect_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_count", bit_count, 16'd0);
        check("reset_state", fsm_state, 2'd0);
        reset = 1'b0;
        drive(1'b0, 1'b0);
        expect_outs("idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // No stuffing: 24 bits LSB first, max run of five 1s
        vec24 = 24'b101011001010100111110101;
        for (int i = 0; i < 24; i++) begin
            drive(vec24[i], 1'b1);
            expect_outs($sformatf("nostuff_b%0d", i), 1'b1, vec24[i], 1'b0, 1'b0);
            check($sformatf("nostuff_cnt%0d", i), bit_count, 16'(i + 1));
        end
        drive(1'b0, 1'b0);
        expect_outs("nostuff_end", 1'b0, vec24[23], 1'b0, 1'b1);
        check("nostuff_count", bit_count, 16'd24);
        drive(1'b0, 1'b0);
        check("nostuff_done_pulse", bs_done, 1'b0);
        check("nostuff_count_hold", bit_count, 16'd24);
        check("nostuff_state_idle", fsm_state, 2'd0);

        // Stuff removal: 1,1,1,1,1,1,0,1 -> the 0 is dropped
        seq_stuff      = 8'b11111101;
        exp_send_stuff = 8'b11111101;
        exp_out        = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(seq_stuff[i], 1'b1);
            if (exp_send_stuff[i]) exp_out = seq_stuff[i];
            expect_outs($sformatf("stuff_b%0d", i), exp_send_stuff[i], exp_out, 1'b0, 1'b0);
        end
        drive(1'b0, 1'b0);
        check("stuff_done", bs_done, 1'b1);
        check("stuff_count", bit_count, 16'd7);

        // Violation: seven 1s, then two discarded bits
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1);
            expect_outs($sformatf("viol_b%0d", i), 1'b1, 1'b1, 1'b0, 1'b0);
        end
        drive(1'b1, 1'b1);
        expect_outs("viol_7th", 1'b0, 1'b1, 1'b1, 1'b0);
        check("viol_state_error", fsm_state, 2'd2);
        drive(1'b0, 1'b1);
        expect_outs("viol_discard0", 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1);
        expect_outs("viol_discard1", 1'b0, 1'b1, 1'b0, 1'b0);
        check("viol_count_frozen", bit_count, 16'd6);
        drive(1'b0, 1'b0);
        expect_outs("viol_end", 1'b0, 1'b1, 1'b0, 1'b1);
        check("viol_count", bit_count, 16'd6);
        check("viol_state_idle", fsm_state, 2'd0);

        // Run broken by a 0: only the trailing 0 after six 1s is dropped
        seq_run = 13'b1111101111110;
        exp_out = out_bit;
        for (int i = 0; i < 13; i++) begin
            drive(seq_run[i], 1'b1);
            if (i < 12) exp_out = seq_run[i];
            expect_outs($sformatf("run_b%0d", i), (i < 12), exp_out, 1'b0, 1'b0);
        end
        drive(1'b0, 1'b0);
        check("run_done", bs_done, 1'b1);
        check("run_count", bit_count, 16'd12);

        // Saturation on the 3-bit counter, restart on the next packet
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);
        check("sat_count_3bit", sat_count, 3'd7);
        check("sat_count_16bit", bit_count, 16'd10);
        check("sat_done", sat_done, 1'b1);
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b1);
        check("sat_restart", sat_count, 3'd1);
        check("sat_restart_out", sat_out_bit, 1'b1);
        drive(1'b0, 1'b0);

        // Reset in the middle of a packet
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b1);
        check("midrst_pre_count", bit_count, 16'd3);
        reset = 1'b1;
        drive(1'b1, 1'b1);
        expect_outs("midrst", 1'b0, 1'b0, 1'b0, 1'b0);
        check("midrst_count", bit_count, 16'd0);
        check("midrst_state", fsm_state, 2'd0);
        check("midrst_sat_count", sat_count, 3'd0);
        reset = 1'b0;
        drive(1'b0, 1'b0);
        check("midrst_no_done", bs_done, 1'b0);
        drive(1'b1, 1'b1);
        expect_outs("after_rst_b0", 1'b1, 1'b1, 1'b0, 1'b0);
        check("after_rst_cnt0", bit_count, 16'd1);
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b1);
        expect_outs("after_rst_b2", 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0);
        check("after_rst_done", bs_done, 1'b1);
        check("after_rst_count", bit_count, 16'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
